// File: rtl/edc_scrubber.sv
// edc_scrubber
// Background SEC-DED (Hamming(39,32) + overall parity) scrubber for the
// 512-line cache data array and its 7-bit parity array. One line at a time
// is read (only while the cache reports idle), checked, and, when a single
// bit error is found, rewritten through the cache's error write ports.
// Correctable and uncorrectable events are counted with saturation.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   start               one-cycle pulse, begins a pass at line 0
//   cache_idle          scrubber may use the array this cycle
//   scrub_rd_en         scrubber owns the array read address
//   scrub_addr          line address being scrubbed
//   data_in, parity_in  asynchronous read data for scrub_addr
//   error_dwe/pwe       write enables for data/parity arrays
//   error_din/pin       corrected data word / re-encoded check bits
//   error_addr          write address (same as scrub_addr)
//   busy, done          pass in progress / end-of-pass pulse
//   ce_count, ue_count  saturating correctable/uncorrectable totals
//   last_ue_addr        line of the most recent uncorrectable error
//
// Build option: define EDC_SCRUB_CONTINUOUS_EN to make the scrubber wrap
// to line 0 after the last line and keep scrubbing until reset.

module edc_scrubber #(
  parameter int DEPTH  = 512,
  parameter int ADDR_W = 9,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              cache_idle,
  output logic              scrub_rd_en,
  output logic [ADDR_W-1:0] scrub_addr,
  input  logic [31:0]       data_in,
  input  logic [6:0]        parity_in,
  output logic              error_dwe,
  output logic              error_pwe,
  output logic [31:0]       error_din,
  output logic [6:0]        error_pin,
  output logic [ADDR_W-1:0] error_addr,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  ce_count,
  output logic [CNT_W-1:0]  ue_count,
  output logic [ADDR_W-1:0] last_ue_addr
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_READ  = 2'd1;
  localparam logic [1:0] S_CHECK = 2'd2;
  localparam logic [1:0] S_FIX   = 2'd3;

  // Check bits {p6..p0}. Walks codeword positions 1..38; data bits occupy
  // the non-power-of-two positions in ascending order, and each data bit
  // contributes to every check bit whose index is set in its position.
  function automatic logic [6:0] f_encode(input logic [31:0] d);
    logic [6:0] p;
    logic [4:0] j;
    p = 7'd0;
    j = 5'd0;
    for (logic [6:0] pos = 7'd1; pos <= 7'd38; pos = pos + 7'd1) begin
      if ((pos & (pos - 7'd1)) != 7'd0) begin
        p[5:0] = p[5:0] ^ (pos[5:0] & {6{d[j]}});
        j = j + 5'd1;
      end else begin
        p = p;
      end
    end
    p[6] = (^d) ^ (^p[5:0]);
    return p;
  endfunction

  // Flip the data bit living at codeword position s. Syndromes that point
  // at a check bit (power of two) or at nothing leave the data unchanged.
  function automatic logic [31:0] f_flip(input logic [31:0] d, input logic [5:0] s);
    logic [31:0] r;
    logic [4:0]  j;
    r = d;
    j = 5'd0;
    for (logic [6:0] pos = 7'd1; pos <= 7'd38; pos = pos + 7'd1) begin
      if ((pos & (pos - 7'd1)) != 7'd0) begin
        if (s == pos[5:0]) begin
          r[j] = ~r[j];
        end else begin
          r = r;
        end
        j = j + 5'd1;
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

  logic [1:0]        r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_data;
  logic [6:0]        r_par;
  logic [31:0]       r_din;
  logic [6:0]        r_pin;
  logic              r_busy;
  logic              r_done;
  logic [CNT_W-1:0]  r_ce;
  logic [CNT_W-1:0]  r_ue;
  logic [ADDR_W-1:0] r_last_ue;

  logic [6:0]        w_enc;
  logic [5:0]        w_syn;
  logic              w_ov;
  logic              w_clean;
  logic              w_ce;
  logic              w_ue;
  logic [31:0]       w_fix_data;
  logic [6:0]        w_fix_par;
  logic              w_last;
  logic [1:0]        w_adv_state;
  logic [ADDR_W-1:0] w_adv_addr;
  logic              w_adv_busy;
  logic              w_adv_done;

  // Syndrome and overall parity; ov=1 with s<=38 is a single-bit error.
  assign w_enc      = f_encode(r_data);
  assign w_syn      = w_enc[5:0] ^ r_par[5:0];
  assign w_ov       = (^r_data) ^ (^r_par);
  assign w_clean    = (w_syn == 6'd0) && !w_ov;
  assign w_ce       = w_ov && (w_syn <= 6'd38);
  assign w_ue       = !w_clean && !w_ce;
  assign w_fix_data = f_flip(r_data, w_syn);
  assign w_fix_par  = f_encode(w_fix_data);
  assign w_last     = (r_addr == ADDR_W'(DEPTH - 1));

  // Where to go after finishing a line.
  always_comb begin
    w_adv_state = S_READ;
    w_adv_addr  = r_addr + ADDR_W'(1);
    w_adv_busy  = 1'b1;
    w_adv_done  = 1'b0;
    if (w_last) begin
      w_adv_addr = {ADDR_W{1'b0}};
      w_adv_done = 1'b1;
`ifdef EDC_SCRUB_CONTINUOUS_EN
      w_adv_state = S_READ;
      w_adv_busy  = 1'b1;
`else
      w_adv_state = S_IDLE;
      w_adv_busy  = 1'b0;
`endif
    end else begin
      w_adv_done = 1'b0;
    end
  end

  // Scrub sequencer, counters and captured correction data.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_addr    <= {ADDR_W{1'b0}};
      r_data    <= 32'd0;
      r_par     <= 7'd0;
      r_din     <= 32'd0;
      r_pin     <= 7'd0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_ce      <= {CNT_W{1'b0}};
      r_ue      <= {CNT_W{1'b0}};
      r_last_ue <= {ADDR_W{1'b0}};
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_addr  <= {ADDR_W{1'b0}};
            r_busy  <= 1'b1;
            r_state <= S_READ;
          end
        end
        S_READ: begin
          if (cache_idle) begin
            r_data  <= data_in;
            r_par   <= parity_in;
            r_state <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (w_ce) begin
            // Corrected word is held here so an idle gap cannot lose it.
            r_din   <= w_fix_data;
            r_pin   <= w_fix_par;
            r_state <= S_FIX;
            if (r_ce != {CNT_W{1'b1}}) begin
              r_ce <= r_ce + CNT_W'(1);
            end
          end else begin
            if (w_ue) begin
              r_last_ue <= r_addr;
              if (r_ue != {CNT_W{1'b1}}) begin
                r_ue <= r_ue + CNT_W'(1);
              end
            end
            r_state <= w_adv_state;
            r_addr  <= w_adv_addr;
            r_busy  <= w_adv_busy;
            r_done  <= w_adv_done;
          end
        end
        S_FIX: begin
          if (cache_idle) begin
            r_state <= w_adv_state;
            r_addr  <= w_adv_addr;
            r_busy  <= w_adv_busy;
            r_done  <= w_adv_done;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Array access strobes follow idle directly; rst masks them in its own cycle.
  assign scrub_rd_en  = !rst && (r_state == S_READ) && cache_idle;
  assign error_dwe    = !rst && (r_state == S_FIX) && cache_idle;
  assign error_pwe    = error_dwe;
  assign error_din    = r_din;
  assign error_pin    = r_pin;
  assign error_addr   = r_addr;
  assign scrub_addr   = r_addr;
  assign busy         = r_busy;
  assign done         = r_done;
  assign ce_count     = r_ce;
  assign ue_count     = r_ue;
  assign last_ue_addr = r_last_ue;

endmodule

// File: tb/tb_edc_scrubber.sv
// Directed bench for edc_scrubber: a table of single-line corruptions with
// hand-computed corrections, plus sequences for idle gaps, mid-pass reset
// and a start pulse while busy.

module tb_edc_scrubber;

  logic        clk = 1'b0;
  logic        rst, start, cache_idle;
  logic        scrub_rd_en;
  logic [8:0]  scrub_addr;
  logic [31:0] data_in;
  logic [6:0]  parity_in;
  logic        error_dwe, error_pwe;
  logic [31:0] error_din;
  logic [6:0]  error_pin;
  logic [8:0]  error_addr;
  logic        busy, done;
  logic [15:0] ce_count, ue_count;
  logic [8:0]  last_ue_addr;

  edc_scrubber dut (
    .clk(clk), .rst(rst), .start(start), .cache_idle(cache_idle),
    .scrub_rd_en(scrub_rd_en), .scrub_addr(scrub_addr),
    .data_in(data_in), .parity_in(parity_in),
    .error_dwe(error_dwe), .error_pwe(error_pwe),
    .error_din(error_din), .error_pin(error_pin), .error_addr(error_addr),
    .busy(busy), .done(done), .ce_count(ce_count), .ue_count(ue_count),
    .last_ue_addr(last_ue_addr)
  );

  always #5 clk = ~clk;

  // Cache model: asynchronous read, written through the error ports.
  logic [31:0] mem_d [512];
  logic [6:0]  mem_p [512];
  assign data_in   = mem_d[scrub_addr];
  assign parity_in = mem_p[scrub_addr];

  int checks   = 0;
  int failures = 0;
  int wr_cnt   = 0;
  logic [8:0]  wr_addr;
  logic [31:0] wr_din;
  logic [6:0]  wr_pin;

  // Write monitor: records writes and flags any write outside idle.
  always @(posedge clk) begin
    if (error_dwe || error_pwe) begin
      wr_cnt  = wr_cnt + 1;
      wr_addr = error_addr;
      wr_din  = error_din;
      wr_pin  = error_pin;
      mem_d[error_addr] = error_din;
      mem_p[error_addr] = error_pin;
      checks = checks + 1;
      if (!cache_idle || (error_dwe != error_pwe) || rst) begin
        failures = failures + 1;
        $display("FAIL write_guard: idle=%0b dwe=%0b pwe=%0b rst=%0b required idle=1 dwe=pwe rst=0",
                 cache_idle, error_dwe, error_pwe, rst);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      failures = failures + 1;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    start = 1'b0;
    cache_idle = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    wr_cnt = 0;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 512; i++) begin
      mem_d[i] = 32'd0;
      mem_p[i] = 7'd0;
    end
  endtask

  task automatic do_start();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Counts rising edges until done is seen; returns lim if it never comes.
  task automatic wait_done(input int lim, output int cyc);
    cyc = 0;
    while (cyc < lim) begin
      @(posedge clk);
      cyc = cyc + 1;
      #1;
      if (done) break;
    end
  endtask

  task automatic wait_addr(input logic [8:0] a);
    int k;
    k = 0;
    while (scrub_addr != a && k < 2000) begin
      @(negedge clk);
      k = k + 1;
    end
    chk("wait_addr_reached", {23'd0, scrub_addr}, {23'd0, a});
  endtask

  typedef struct {
    logic [8:0]  addr;
    logic [31:0] data;
    logic [6:0]  par;
    int          exp_wr;
    logic [31:0] exp_din;
    logic [6:0]  exp_pin;
    int          exp_ce;
    int          exp_ue;
    logic [8:0]  exp_last_ue;
    int          exp_cyc;
  } vec_t;

  vec_t vecs [10];
  int   cyc;

  initial begin
    // clean, d0 flip, p6 flip, double, p2 flip, d31 flip, d1 flip on a
    // nonzero word, s=63 with ov=1, last line p0 flip, line 0 d2 flip
    vecs[0] = '{9'd0,   32'h0000_0000, 7'h00, 0, 32'h0,         7'h00, 0, 0, 9'd0,   1024};
    vecs[1] = '{9'd5,   32'h0000_0001, 7'h00, 1, 32'h0,         7'h00, 1, 0, 9'd0,   1025};
    vecs[2] = '{9'd9,   32'h0000_0000, 7'h40, 1, 32'h0,         7'h00, 1, 0, 9'd0,   1025};
    vecs[3] = '{9'd12,  32'h0000_0003, 7'h00, 0, 32'h0,         7'h00, 0, 1, 9'd12,  1024};
    vecs[4] = '{9'd20,  32'h0000_0000, 7'h04, 1, 32'h0,         7'h00, 1, 0, 9'd0,   1025};
    vecs[5] = '{9'd33,  32'h8000_0000, 7'h00, 1, 32'h0,         7'h00, 1, 0, 9'd0,   1025};
    vecs[6] = '{9'd40,  32'h0000_0003, 7'h43, 1, 32'h0000_0001, 7'h43, 1, 0, 9'd0,   1025};
    vecs[7] = '{9'd100, 32'h0000_0000, 7'h7F, 0, 32'h0,         7'h00, 0, 1, 9'd100, 1024};
    vecs[8] = '{9'd511, 32'h0000_0000, 7'h01, 1, 32'h0,         7'h00, 1, 0, 9'd0,   1025};
    vecs[9] = '{9'd0,   32'h0000_0004, 7'h00, 1, 32'h0,         7'h00, 1, 0, 9'd0,   1025};

    clear_mem();
    apply_reset();

    // Reset state
    chk("rst_busy",    {31'd0, busy},        32'd0);
    chk("rst_done",    {31'd0, done},        32'd0);
    chk("rst_rd_en",   {31'd0, scrub_rd_en}, 32'd0);
    chk("rst_dwe",     {31'd0, error_dwe},   32'd0);
    chk("rst_din",     error_din,            32'd0);
    chk("rst_pin",     {25'd0, error_pin},   32'd0);
    chk("rst_addr",    {23'd0, scrub_addr},  32'd0);
    chk("rst_ce",      {16'd0, ce_count},    32'd0);
    chk("rst_ue",      {16'd0, ue_count},    32'd0);
    chk("rst_last_ue", {23'd0, last_ue_addr}, 32'd0);

    // Table of single-line scenarios, one full pass each
    for (int v = 0; v < 10; v++) begin
      apply_reset();
      clear_mem();
      mem_d[vecs[v].addr] = vecs[v].data;
      mem_p[vecs[v].addr] = vecs[v].par;
      do_start();
      wait_done(4000, cyc);
      chk($sformatf("v%0d_cycles", v), cyc, vecs[v].exp_cyc);
      chk($sformatf("v%0d_writes", v), wr_cnt, vecs[v].exp_wr);
      if (vecs[v].exp_wr != 0) begin
        chk($sformatf("v%0d_wr_addr", v), {23'd0, wr_addr}, {23'd0, vecs[v].addr});
        chk($sformatf("v%0d_wr_din", v), wr_din, vecs[v].exp_din);
        chk($sformatf("v%0d_wr_pin", v), {25'd0, wr_pin}, {25'd0, vecs[v].exp_pin});
      end
      chk($sformatf("v%0d_ce", v), {16'd0, ce_count}, vecs[v].exp_ce);
      chk($sformatf("v%0d_ue", v), {16'd0, ue_count}, vecs[v].exp_ue);
      chk($sformatf("v%0d_last_ue", v), {23'd0, last_ue_addr}, {23'd0, vecs[v].exp_last_ue});
`ifdef EDC_SCRUB_CONTINUOUS_EN
      chk($sformatf("v%0d_busy", v), {31'd0, busy}, 32'd1);
`else
      chk($sformatf("v%0d_busy", v), {31'd0, busy}, 32'd0);
`endif
    end

    // Idle drops while a correction is pending: write waits, then happens once
    apply_reset();
    clear_mem();
    mem_d[5] = 32'h0000_0001;
    do_start();
    wait_addr(9'd5);
    @(negedge clk);
    cache_idle = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("gap_dwe_low", {31'd0, error_dwe}, 32'd0);
      chk("gap_rd_en_low", {31'd0, scrub_rd_en}, 32'd0);
    end
    chk("gap_no_write_yet", wr_cnt, 0);
    cache_idle = 1'b1;
    wait_done(4000, cyc);
    chk("gap_writes", wr_cnt, 1);
    chk("gap_wr_addr", {23'd0, wr_addr}, 32'd5);
    chk("gap_wr_din", wr_din, 32'd0);
    chk("gap_wr_pin", {25'd0, wr_pin}, 32'd0);
    chk("gap_ce", {16'd0, ce_count}, 32'd1);

    // Reset while a write is being offered at line 300, then restart
    apply_reset();
    clear_mem();
    mem_d[300] = 32'h0000_0001;
    do_start();
    wait_addr(9'd300);
    @(negedge clk);
    @(negedge clk);
    chk("pre_rst_dwe", {31'd0, error_dwe}, 32'd1);
    rst = 1'b1;
    #1;
    chk("rst_cycle_dwe", {31'd0, error_dwe}, 32'd0);
    chk("rst_cycle_pwe", {31'd0, error_pwe}, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    chk("abort_writes", wr_cnt, 0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_ce", {16'd0, ce_count}, 32'd0);
    chk("abort_addr", {23'd0, scrub_addr}, 32'd0);
    do_start();
    wait_done(4000, cyc);
    chk("restart_cycles", cyc, 1025);
    chk("restart_writes", wr_cnt, 1);
    chk("restart_wr_addr", {23'd0, wr_addr}, 32'd300);
    chk("restart_ce", {16'd0, ce_count}, 32'd1);

    // start while busy must not restart the pass
    apply_reset();
    clear_mem();
    do_start();
    repeat (200) @(posedge clk);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(4000, cyc);
    chk("busy_start_ignored", cyc, 823);

    // After a pass: continuous build repeats every 1024 cycles, else stays idle
`ifdef EDC_SCRUB_CONTINUOUS_EN
    wait_done(4000, cyc);
    chk("continuous_period", cyc, 1024);
    chk("continuous_busy", {31'd0, busy}, 32'd1);
`else
    wait_done(1100, cyc);
    chk("single_pass_no_done", cyc, 1100);
    chk("single_pass_idle", {31'd0, busy}, 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
